sram_mem_controller: RTL and testbench
======================================

# sram_mem_controller

Memory-stage responder that services the pipeline's `MEM_R_EN`/`MEM_W_EN` requests against an external 16-bit-wide SRAM. Each 32-bit access becomes two 16-bit SRAM cycles. While busy, the controller holds `ready` low to freeze the pipeline. It is a drop-in replacement for the single-cycle data memory, with the same pipeline-side port set plus `ready`.

## Interface
- `BASE_ADDR`, 1024: first byte address of data memory.
- `ADDR_W`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 1: extra cycles per 16-bit half. Must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `storeValue`  in  32  write data.
- `address`  in  32  byte address; bits [1:0] ignored.
- `MEM_W_EN`  in  1  write request.
- `MEM_R_EN`  in  1  read request.
- `loadValue`  out  32  registered read data.
- `ready`  out  1  low means the pipeline must freeze.
- `SRAM_ADDR`  out  ADDR_W  half-word address.
- `SRAM_DQ_OUT`  out  16  write data to SRAM.
- `SRAM_DQ_IN`  in  16  read data from SRAM.
- `SRAM_DQ_OE`  out  1  drive enable for the data bus.
- `SRAM_WE_N`  out  1  SRAM write strobe, active-low.

## Operation
- Address mapping:
  - word index = (address − BASE_ADDR) >> 2.
  - Low half (bits [15:0]) goes to SRAM address {index, 0].
  - High half (bits [31:16]) goes to SRAM address {index, 1}.
  - Index is truncated to ADDR_W−1 bits, so addresses wrap modulo SRAM depth.
- FSM states:
  - IDLE: with no request, stay. With `MEM_W_EN` or `MEM_R_EN`, latch address, write data and op, then go to LO.
  - LO: WAIT_CYCLES+1 cycles on the low half, then HI.
  - HI: WAIT_CYCLES+1 cycles on the high half, then DONE.
  - DONE: one cycle, then IDLE.
- Simultaneous `MEM_W_EN` and `MEM_R_EN`: treated as a write.
- Writes:
  - `SRAM_DQ_OE` is 1 throughout LO and HI.
  - `SRAM_WE_N` is high in the first cycle of each half (setup) and low in the remaining WAIT_CYCLES cycles.
- Reads:
  - `SRAM_DQ_IN` is sampled on the last cycle of LO (low half) and the last cycle of HI (high half).
  - `loadValue` is updated on entry to DONE and holds otherwise, including after writes.
- Requests are not abortable. Deasserting the request mid-access does not stop it.
- Inputs are ignored outside IDLE; the latched copies are used.
- If a request is still present in the IDLE cycle after DONE, a new access starts (back-to-back memory instructions).

## Timing
- `ready` is combinational:
  - In IDLE: ready = ~(MEM_R_EN | MEM_W_EN).
  - In LO and HI: 0.
  - In DONE: 1.
- Request first seen in cycle 0:
  - `ready` is low for cycles 0 … 2·(WAIT_CYCLES+1).
  - `ready` is high in DONE.
  - With defaults: `ready` low for 5 cycles, DONE in cycle 5.
- Read data is valid on `loadValue` from the DONE cycle onward.
- Reset values: `loadValue`=0, `ready`=1, `SRAM_ADDR`=0, `SRAM_DQ_OUT`=0, `SRAM_DQ_OE`=0, `SRAM_WE_N`=1, state=IDLE.
- Reset asserted mid-access:
  - `SRAM_WE_N` goes high immediately (asynchronously).
  - The half-written word is left as is; no rollback.

## Configuration
- Macro: `SRAM_BOUNDS_CHECK_EN`.
- Defined — an access is in range iff address ≥ BASE_ADDR and word index < 2^(ADDR_W−1). An out-of-range access:
  - goes IDLE → DONE directly, so `ready` is low for cycle 0 only;
  - never drives `SRAM_WE_N` low;
  - for reads, sets `loadValue` to 0.
- Not defined: no range check; addresses wrap as described under Operation.

## Structure
- Package `sram_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the BASE_ADDR default;
  - the data width (32) and SRAM data width (16).
- Sub-module `sram_addr_map` (combinational) computes the word index, the two half addresses, and the in-range flag.
- The FSM, latches and data path live in the top module.

## Test plan
- Write 10 to 1024 → SRAM[0]=0x000A, SRAM[1]=0x0000; `ready` low for 5 cycles; `SRAM_WE_N` pulses low exactly 2 times.
- Write 0xDEADBEEF to 1028, then read 1028 → SRAM[2]=0xBEEF, SRAM[3]=0xDEAD; `loadValue`=0xDEADBEEF in DONE.
- Read 1029 after the above → `loadValue`=0xDEADBEEF (bits [1:0] ignored).
- `MEM_W_EN`=`MEM_R_EN`=1, address 1024, data 7 → write performed; a later read returns 7; `loadValue` unchanged during the write.
- Drop `rst_n` during HI of a write → `SRAM_WE_N`=1 and `ready`=1 without waiting for a clock edge; the next access completes normally.
- With `SRAM_BOUNDS_CHECK_EN`, read address 512 → `ready` low 1 cycle, `loadValue`=0, no SRAM bus activity.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit SRAM data-memory controller.
package sram_pkg;

  // First byte address of data memory when the instantiation does not override it.
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  // Pipeline word width and external SRAM data width.
  localparam int DATA_W  = 32;
  localparam int SRAM_DW = 16;

  // Access sequencer: low half, high half, then a one-cycle completion slot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side memory-stage bus: request, address and data in, load data and
// ready (stall) out. The pipeline is the master, the controller the slave.
interface sram_mem_controller_if;
  import sram_pkg::*;

  logic [DATA_W-1:0] storeValue;
  logic [DATA_W-1:0] address;
  logic              MEM_W_EN;
  logic              MEM_R_EN;
  logic [DATA_W-1:0] loadValue;
  logic              ready;

  modport master (
    output storeValue, address, MEM_W_EN, MEM_R_EN,
    input  loadValue, ready
  );

  modport slave (
    input  storeValue, address, MEM_W_EN, MEM_R_EN,
    output loadValue, ready
  );

endinterface

// File: rtl/sram_addr_map.sv
// Byte address to SRAM half-word address mapping, plus the in-range flag.
// With SRAM_BOUNDS_CHECK_EN defined, the flag is real: address must be at or
// above BASE_ADDR and the word index must fit in ADDR_W-1 bits. Otherwise the
// flag is tied high and the index simply wraps modulo the SRAM depth.
module sram_addr_map
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          ADDR_W    = 18
) (
  input  logic [DATA_W-1:0] i_address,
  output logic [ADDR_W-1:0] o_addr_lo,
  output logic [ADDR_W-1:0] o_addr_hi,
  output logic              o_in_range
);

  logic [31:0]       w_offset;
  logic [29:0]       w_index_full;
  logic [ADDR_W-2:0] w_index;

  // Byte offset into data memory; bits [1:0] select a byte and are dropped.
  assign w_offset     = i_address - BASE_ADDR;
  assign w_index_full = w_offset[31:2];
  assign w_index      = w_index_full[ADDR_W-2:0];

  // Each word occupies two consecutive SRAM half-words, low half first.
  assign o_addr_lo = {w_index, 1'b0};
  assign o_addr_hi = {w_index, 1'b1};

`ifdef SRAM_BOUNDS_CHECK_EN
  logic w_unused_bits;
  assign w_unused_bits = ^w_offset[1:0];
  // Below BASE_ADDR, or an index needing more than ADDR_W-1 bits, is out of range.
  assign o_in_range = (i_address >= BASE_ADDR) &&
                      ((w_index_full >> (ADDR_W - 1)) == '0);
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{w_offset[1:0], w_index_full[29:ADDR_W-1]};
  assign o_in_range    = 1'b1;
`endif

endmodule

// File: rtl/sram_mem_controller.sv
// Memory-stage responder for a 16-bit external SRAM. Each 32-bit access is
// split into a low and a high half-word cycle of WAIT_CYCLES+1 clocks each;
// ready stays low until the DONE slot so the pipeline freezes meanwhile.
// Optional feature: SRAM_BOUNDS_CHECK_EN turns out-of-range accesses into a
// one-cycle no-op (reads return 0, no SRAM write strobe).
module sram_mem_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_mem_controller_if.slave  bus,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  output logic [SRAM_DW-1:0]    SRAM_DQ_OUT,
  input  logic [SRAM_DW-1:0]    SRAM_DQ_IN,
  output logic                  SRAM_DQ_OE,
  output logic                  SRAM_WE_N
);

  localparam int             CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr_lo;
  logic [ADDR_W-1:0]   r_addr_hi;
  logic [DATA_W-1:0]   r_wdata;
  logic [SRAM_DW-1:0]  r_rdata_lo;
  logic [DATA_W-1:0]   r_load_value;

  logic                w_req;
  logic                w_start;
  logic                w_cnt_last;
  logic                w_in_access;
  logic                w_ready;
  logic [ADDR_W-1:0]   w_addr_lo;
  logic [ADDR_W-1:0]   w_addr_hi;
  logic                w_in_range;

  sram_addr_map #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_addr_map (
    .i_address  (bus.address),
    .o_addr_lo  (w_addr_lo),
    .o_addr_hi  (w_addr_hi),
    .o_in_range (w_in_range)
  );

  // Simultaneous read and write requests resolve to a write (r_is_write latches MEM_W_EN).
  assign w_req       = bus.MEM_W_EN | bus.MEM_R_EN;
  assign w_start     = (r_state == IDLE) && w_req;
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_in_access = (r_state == LO) || (r_state == HI);

  // State register; reset drops straight to IDLE, releasing the write strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic plus ready and SRAM strobes, all decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    w_next_state = r_state;
    w_ready      = 1'b1;
    SRAM_DQ_OE   = 1'b0;
    SRAM_WE_N    = 1'b1;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
        if (w_req) w_next_state = w_in_range ? LO : DONE;
      end
      LO: begin
        w_ready    = 1'b0;
        SRAM_DQ_OE = r_is_write;
        SRAM_WE_N  = ~(r_is_write && (r_cnt != '0));
        if (w_cnt_last) w_next_state = HI;
      end
      HI: begin
        w_ready    = 1'b0;
        SRAM_DQ_OE = r_is_write;
        SRAM_WE_N  = ~(r_is_write && (r_cnt != '0));
        if (w_cnt_last) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.ready     = w_ready;
  assign bus.loadValue = r_load_value;

  // Address and data lines follow the latched request; the half is chosen by state.
  assign SRAM_ADDR   = (r_state == HI) ? r_addr_hi : r_addr_lo;
  assign SRAM_DQ_OUT = (r_state == HI) ? r_wdata[DATA_W-1:SRAM_DW] : r_wdata[SRAM_DW-1:0];

  // Per-half cycle counter: first cycle is setup, the remaining ones are the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)                          r_cnt <= '0;
    else if (w_in_access && !w_cnt_last) r_cnt <= r_cnt + CNT_W'(1);
    else                                 r_cnt <= '0;
  end

  // Capture the request in IDLE; later pipeline changes are ignored until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_write <= 1'b0;
      r_addr_lo  <= '0;
      r_addr_hi  <= '0;
      r_wdata    <= '0;
    end else if (w_start) begin
      r_is_write <= bus.MEM_W_EN;
      if (w_in_range) begin
        r_addr_lo <= w_addr_lo;
        r_addr_hi <= w_addr_hi;
        if (bus.MEM_W_EN) r_wdata <= bus.storeValue;
      end
    end
  end

  // Read data path: low half parked, full word committed on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_lo   <= '0;
      r_load_value <= '0;
    end else begin
      if ((r_state == LO) && w_cnt_last && !r_is_write)
        r_rdata_lo <= SRAM_DQ_IN;
      if ((r_state == HI) && w_cnt_last && !r_is_write)
        r_load_value <= {SRAM_DQ_IN, r_rdata_lo};
      else if (w_start && !w_in_range && !bus.MEM_W_EN)
        r_load_value <= '0;
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller with a behavioural 16-bit SRAM, a table of
// pipeline accesses, a load-value scoreboard, and hand-written sequences for
// simultaneous requests, back-to-back accesses and reset in mid-write.
module tb_sram_mem_controller;
  import sram_pkg::*;

  localparam int ADDR_W = 18;

`ifdef SRAM_BOUNDS_CHECK_EN
  localparam int          OOR_LOW   = 1;
  localparam logic [31:0] WRAP_LOAD = 32'h0000_0000;
`else
  localparam int          OOR_LOW   = 5;
  localparam logic [31:0] WRAP_LOAD = 32'h0000_000A;
`endif

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_mem_controller_if bus ();

  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic [15:0]       sram_dq_in;
  logic              sram_dq_oe;
  logic              sram_we_n;

  sram_mem_controller #(
    .BASE_ADDR   (32'd1024),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ_OUT (sram_dq_out),
    .SRAM_DQ_IN  (sram_dq_in),
    .SRAM_DQ_OE  (sram_dq_oe),
    .SRAM_WE_N   (sram_we_n)
  );

  // Behavioural SRAM: writes commit on a clock edge with WE_N low, reads are asynchronous.
  bit [15:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (sram_dq_oe && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = mem[sram_addr];

  int we_pulses = 0;
  int oe_cycles = 0;
  always @(negedge sram_we_n) we_pulses++;
  always @(posedge clk) if (sram_dq_oe) oe_cycles++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_load;
    int          exp_low;
    int          exp_pulses;
    int          exp_oe;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] sb_q [$];
  logic [31:0] model_load;

  // Wait (bounded) for the DONE cycle, counting stalled cycles and flagging any
  // loadValue movement away from 'hold' while the pipeline is frozen.
  task automatic wait_done(input logic [31:0] hold, output int low, output bit to, output bit moved);
    low   = 0;
    to    = 1'b1;
    moved = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        to = 1'b0;
        break;
      end
      if (bus.loadValue !== hold) moved = 1'b1;
      low++;
    end
  endtask

  // One access: request presented for a single cycle, then dropped (not abortable).
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] hold,
                            output int low, output bit to, output bit moved,
                            output logic [31:0] load);
    int rest;
    @(negedge clk);
    bus.storeValue = data;
    bus.address    = addr;
    bus.MEM_W_EN   = wr;
    bus.MEM_R_EN   = rd;
    #1;
    low = bus.ready ? 0 : 1;
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b0;
    bus.MEM_R_EN = 1'b0;
    wait_done(hold, rest, to, moved);
    low  = low + rest;
    load = bus.loadValue;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          low;
    bit          to;
    bit          moved;
    logic [31:0] load;
    int          p0;
    int          o0;

    rst_n          = 1'b0;
    bus.storeValue = '0;
    bus.address    = '0;
    bus.MEM_W_EN   = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    model_load     = '0;

    vecs[0] = '{1'b1, 1'b0, 32'd1024,   32'd10,        32'h0,         5,       2, 4};
    vecs[1] = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF,  32'h0,         5,       2, 4};
    vecs[2] = '{1'b0, 1'b1, 32'd1028,   32'h0,         32'hDEADBEEF,  5,       0, 0};
    vecs[3] = '{1'b0, 1'b1, 32'd1029,   32'h0,         32'hDEADBEEF,  5,       0, 0};
    vecs[4] = '{1'b1, 1'b0, 32'd1044,   32'h12345678,  32'h0,         5,       2, 4};
    vecs[5] = '{1'b0, 1'b1, 32'd1046,   32'h0,         32'h12345678,  5,       0, 0};
    vecs[6] = '{1'b0, 1'b1, 32'd1024,   32'h0,         32'h0000000A,  5,       0, 0};
    vecs[7] = '{1'b0, 1'b1, 32'd525312, 32'h0,         WRAP_LOAD,     OOR_LOW, 0, 0};
    vecs[8] = '{1'b0, 1'b1, 32'd512,    32'h0,         32'h0,         OOR_LOW, 0, 0};

    // Reset state.
    #12;
    check("reset ready",     32'(bus.ready),  32'd1);
    check("reset loadValue", bus.loadValue,   32'h0);
    check("reset SRAM_ADDR", 32'(sram_addr),  32'h0);
    check("reset DQ_OUT",    32'(sram_dq_out), 32'h0);
    check("reset DQ_OE",     32'(sram_dq_oe), 32'd0);
    check("reset WE_N",      32'(sram_we_n),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven accesses.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rd && !vecs[i].wr) sb_q.push_back(vecs[i].exp_load);
      p0 = we_pulses;
      o0 = oe_cycles;
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, model_load, low, to, moved, load);
      check($sformatf("row%0d timeout", i),    32'(to),             32'd0);
      check($sformatf("row%0d ready_low", i),  32'(low),            32'(vecs[i].exp_low));
      check($sformatf("row%0d we_pulses", i),  32'(we_pulses - p0), 32'(vecs[i].exp_pulses));
      check($sformatf("row%0d oe_cycles", i),  32'(oe_cycles - o0), 32'(vecs[i].exp_oe));
      if (vecs[i].rd && !vecs[i].wr) begin
        if (sb_q.size() > 0) check($sformatf("row%0d loadValue", i), load, sb_q.pop_front());
        model_load = vecs[i].exp_load;
      end else begin
        check($sformatf("row%0d load_held", i), 32'(moved), 32'd0);
        check($sformatf("row%0d load_done", i), load,       model_load);
      end
    end

    check("mem[0]", 32'(mem[0]), 32'h0000_000A);
    check("mem[1]", 32'(mem[1]), 32'h0000_0000);
    check("mem[2]", 32'(mem[2]), 32'h0000_BEEF);
    check("mem[3]", 32'(mem[3]), 32'h0000_DEAD);

    // Simultaneous write and read enables: performed as a write, loadValue untouched.
    p0 = we_pulses;
    run_access(1'b1, 1'b1, 32'd1024, 32'd7, model_load, low, to, moved, load);
    check("both ready_low", 32'(low),            32'd5);
    check("both we_pulses", 32'(we_pulses - p0), 32'd2);
    check("both load_held", 32'(moved),          32'd0);
    check("both load_done", load,                model_load);
    sb_q.push_back(32'd7);
    run_access(1'b0, 1'b1, 32'd1024, 32'd0, model_load, low, to, moved, load);
    if (sb_q.size() > 0) check("both readback", load, sb_q.pop_front());
    model_load = 32'd7;

    // Back-to-back reads: request held through DONE starts a second access.
    @(negedge clk);
    bus.address  = 32'd1028;
    bus.MEM_R_EN = 1'b1;
    sb_q.push_back(32'hDEADBEEF);
    sb_q.push_back(32'hDEADBEEF);
    wait_done(model_load, low, to, moved);
    check("b2b first timeout", 32'(to),  32'd0);
    check("b2b first low",     32'(low), 32'd4);
    if (sb_q.size() > 0) check("b2b first load", bus.loadValue, sb_q.pop_front());
    @(negedge clk);
    check("b2b restart ready", 32'(bus.ready), 32'd0);
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b0;
    wait_done(32'hDEADBEEF, low, to, moved);
    check("b2b second timeout", 32'(to), 32'd0);
    if (sb_q.size() > 0) check("b2b second load", bus.loadValue, sb_q.pop_front());
    model_load = 32'hDEADBEEF;

    // Reset during the strobe cycle of the high half of a write.
    @(negedge clk);
    bus.address    = 32'd1032;
    bus.storeValue = 32'hCAFEF00D;
    bus.MEM_W_EN   = 1'b1;
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-HI WE_N low", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst WE_N async",  32'(sram_we_n),  32'd1);
    check("rst ready async", 32'(bus.ready),  32'd1);
    check("rst DQ_OE async", 32'(sram_dq_oe), 32'd0);
    check("rst lo half kept", 32'(mem[4]),    32'h0000_F00D);
    @(negedge clk);
    rst_n      = 1'b1;
    model_load = 32'h0;

    // Recovery: next write/read pair completes normally.
    run_access(1'b1, 1'b0, 32'd1032, 32'h11112222, model_load, low, to, moved, load);
    check("post-rst write low", 32'(low), 32'd5);
    sb_q.push_back(32'h11112222);
    run_access(1'b0, 1'b1, 32'd1032, 32'd0, model_load, low, to, moved, load);
    check("post-rst read low", 32'(low), 32'd5);
    if (sb_q.size() > 0) check("post-rst read load", load, sb_q.pop_front());
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
